hilo_ctrl: RTL and testbench

- Sequencing and result-holding stage directly downstream of the Booth multiplier (and the sibling divider).
- Accepts mult/div start requests from the control unit, clears and runs the selected arithmetic unit, and waits for its done flag.
- Latches the unit's 64-bit result into architectural HI/LO registers and stalls the pipeline while busy.
- Also services mthi/mtlo writes; HI/LO are read combinationally by mfhi/mflo.

---
 rtl/hilo_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_hilo_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_ctrl
//
// Sequencing and result-holding stage that sits behind the Booth multiplier
// and the sibling divider. A start request from the control unit picks one
// arithmetic unit, gives it a one-cycle clear, then holds its run enable until
// the unit reports done. The unit's 64-bit result is latched into the
// architectural HI/LO registers. While an operation is in flight the pipeline
// is stalled through busy. mthi/mtlo writes are serviced whenever no
// operation is in flight. HI/LO are exposed directly so that mfhi/mflo can
// read them combinationally.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   start_mult/start_div one-cycle start requests (mult has priority)
//   mthi, mtlo, wr_data  direct architectural writes to HI/LO
//   mult_hi/lo/done      multiplier result words and level done flag
//   div_hi/lo/done       divider remainder/quotient and level done flag
//   mult_clr, div_clr    one-cycle clear to the selected unit
//   mult_init, div_init  run enable to the selected unit (level)
//   hi_q, lo_q           architectural HI/LO registers
//   busy                 pipeline stall request
//   done                 one-cycle pulse: new result visible in HI/LO
//   timeout_err          sticky flag: a run was aborted on timeout
//
// Every output comes either straight from a flop or from a decode of the
// registered state and unit selection, so there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module hilo_ctrl #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        mult_done,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div_done,
  output logic        mult_clr,
  output logic        mult_init,
  output logic        div_clr,
  output logic        div_init,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    SEL_MULT = 1'b0,
    SEL_DIV  = 1'b1
  } sel_t;

  // Last RUN cycle count value before the run is abandoned.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  sel_t             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_d, lo_d;
  logic             timeout_err_q, timeout_err_d;

  // Done flag and result words of whichever unit is currently selected; the
  // other unit's outputs never influence HI/LO or the sequencing.
  logic        unit_done;
  logic [31:0] unit_hi;
  logic [31:0] unit_lo;

  // Route the selected unit's handshake and result into one common view so
  // the sequencer below does not need to care which unit is running.
  always_comb begin
    unit_done = mult_done;
    unit_hi   = mult_hi;
    unit_lo   = mult_lo;
    if (sel_q == SEL_DIV) begin
      unit_done = div_done;
      unit_hi   = div_hi;
      unit_lo   = div_lo;
    end
  end

  // State register plus HI/LO and the bookkeeping flops. Reset returns the
  // block to IDLE with the multiplier selected and wipes HI/LO, which also
  // abandons any run that happens to be in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sel_q         <= SEL_MULT;
      cnt_q         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state and register update logic. Everything holds by default; each
  // state only overrides what it actually changes.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        // Direct writes land at this edge. If a start comes in the same
        // cycle, the unit's result later overwrites whatever was written.
        if (mthi) hi_d = wr_data;
        if (mtlo) lo_d = wr_data;
        if (start_mult) begin
          sel_d   = SEL_MULT;
          state_d = CLEAR;
        end else if (start_div) begin
          sel_d   = SEL_DIV;
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        cnt_d   = '0;
        state_d = RUN;
      end

      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A done seen on the very last allowed cycle still counts as a
        // successful run, so it is tested ahead of the timeout.
        if (unit_done) begin
          hi_d    = unit_hi;
          lo_d    = unit_lo;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end

      DONE: begin
        // Writes are honoured here too, but a start is not: the requester
        // sees busy low and must ask again once we are back in IDLE.
        if (mthi) hi_d = wr_data;
        if (mtlo) lo_d = wr_data;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from registered state only.
  assign mult_clr    = (state_q == CLEAR) && (sel_q == SEL_MULT);
  assign div_clr     = (state_q == CLEAR) && (sel_q == SEL_DIV);
  assign mult_init   = (state_q == RUN)   && (sel_q == SEL_MULT);
  assign div_init    = (state_q == RUN)   && (sel_q == SEL_DIV);
  assign busy        = (state_q == CLEAR) || (state_q == RUN);
  assign done        = (state_q == DONE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_ctrl
//
// Directed-plus-random bench for hilo_ctrl. The bench plays the part of both
// arithmetic units and of the control unit. Each operation is described at
// transaction level (which unit, on which RUN cycle done appears, result
// words), and the expected waveform is derived from cycle offsets relative to
// the start pulse rather than from any state machine.
// -----------------------------------------------------------------------------
module tb_hilo_ctrl;

  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult, start_div, mthi, mtlo;
  logic [31:0] wr_data;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic        mult_done, div_done;
  logic        mult_clr, mult_init, div_clr, div_init;
  logic [31:0] hi_q, lo_q;
  logic        busy, done, timeout_err;

  int checks = 0;
  int errors = 0;

  // Architectural view held by the bench: what HI/LO and the sticky error
  // flag should be whenever no operation is in flight.
  logic [31:0] m_hi, m_lo;
  logic        m_terr;

  hilo_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .wr_data    (wr_data),
    .mult_hi    (mult_hi),
    .mult_lo    (mult_lo),
    .mult_done  (mult_done),
    .div_hi     (div_hi),
    .div_lo     (div_lo),
    .div_done   (div_done),
    .mult_clr   (mult_clr),
    .mult_init  (mult_init),
    .div_clr    (div_clr),
    .div_init   (div_init),
    .hi_q       (hi_q),
    .lo_q       (lo_q),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Hard stop in case something unforeseen stalls the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic checkCtrl(input string tag, input int k, input bit e_mclr,
                           input bit e_minit, input bit e_dclr,
                           input bit e_dinit, input bit e_busy,
                           input bit e_done, input logic [31:0] e_hi,
                           input logic [31:0] e_lo, input bit e_terr);
    checkOutput($sformatf("%s mult_clr k=%0d", tag, k), 32'(mult_clr), 32'(e_mclr));
    checkOutput($sformatf("%s mult_init k=%0d", tag, k), 32'(mult_init), 32'(e_minit));
    checkOutput($sformatf("%s div_clr k=%0d", tag, k), 32'(div_clr), 32'(e_dclr));
    checkOutput($sformatf("%s div_init k=%0d", tag, k), 32'(div_init), 32'(e_dinit));
    checkOutput($sformatf("%s busy k=%0d", tag, k), 32'(busy), 32'(e_busy));
    checkOutput($sformatf("%s done k=%0d", tag, k), 32'(done), 32'(e_done));
    checkOutput($sformatf("%s hi_q k=%0d", tag, k), hi_q, e_hi);
    checkOutput($sformatf("%s lo_q k=%0d", tag, k), lo_q, e_lo);
    checkOutput($sformatf("%s timeout_err k=%0d", tag, k), 32'(timeout_err), 32'(e_terr));
  endtask

  task automatic applyStimulus(input bit sm, input bit sd, input bit wh,
                               input bit wl, input logic [31:0] wd,
                               input bit rst);
    start_mult = sm;
    start_div  = sd;
    mthi       = wh;
    mtlo       = wl;
    wr_data    = wd;
    reset      = rst;
  endtask

  task automatic doReset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      applyStimulus(0, 0, 0, 0, 32'h0, 1);
    end
    @(posedge clk); #1;
    applyStimulus(0, 0, 0, 0, 32'h0, 0);
    @(negedge clk);
    m_hi = 32'h0; m_lo = 32'h0; m_terr = 1'b0;
    checkCtrl("reset", 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
  endtask

  // One-cycle architectural write while idle, then check it next cycle.
  task automatic writeHiLo(input bit wh, input bit wl, input logic [31:0] val);
    @(posedge clk); #1;
    applyStimulus(0, 0, wh, wl, val, 0);
    @(posedge clk); #1;
    applyStimulus(0, 0, 0, 0, 32'h0, 0);
    @(negedge clk);
    if (wh) m_hi = val;
    if (wl) m_lo = val;
    checkCtrl("write", 0, 0, 0, 0, 0, 0, 0, m_hi, m_lo, m_terr);
  endtask

  // One operation. k counts cycles from the start pulse (k=0). n_done is the
  // RUN cycle on which the selected unit raises done (0 means never).
  // reset_at, when non-zero, asserts reset during that RUN cycle.
  task automatic runOp(input string tag, input bit do_mult, input bit do_div,
                       input int n_done, input logic [31:0] rhi,
                       input logic [31:0] rlo, input bit pre_hi,
                       input bit pre_lo, input logic [31:0] pre_val,
                       input int reset_at);
    bit          sel_m;
    int          run_end, last;
    logic [31:0] old_hi, old_lo, e_hi, e_lo;
    bit          e_busy, e_clr, e_init, e_done, e_terr, got_res;

    sel_m   = do_mult;
    run_end = (n_done != 0) ? 1 + n_done : 1 + TIMEOUT;
    last    = (reset_at != 0) ? reset_at + 2 :
              ((n_done != 0) ? 2 + n_done : 2 + TIMEOUT);
    old_hi  = pre_hi ? pre_val : m_hi;
    old_lo  = pre_lo ? pre_val : m_lo;

    for (int k = 0; k <= last; k++) begin
      @(posedge clk); #1;
      if (k == 0)
        applyStimulus(do_mult, do_div, pre_hi, pre_lo, pre_val, 0);
      else if (k < last && k <= run_end)
        applyStimulus($urandom % 4 == 0, $urandom % 4 == 0, $urandom % 3 == 0,
                      $urandom % 3 == 0, $urandom,
                      reset_at != 0 && k == reset_at + 1);
      else
        applyStimulus(0, 0, 0, 0, 32'h0, 0);

      if (sel_m) begin
        mult_done = (n_done != 0) && (k >= 1 + n_done);
        mult_hi   = rhi;
        mult_lo   = rlo;
        div_done  = ($urandom % 2) == 1;
        div_hi    = $urandom;
        div_lo    = $urandom;
      end else begin
        div_done  = (n_done != 0) && (k >= 1 + n_done);
        div_hi    = rhi;
        div_lo    = rlo;
        mult_done = ($urandom % 2) == 1;
        mult_hi   = $urandom;
        mult_lo   = $urandom;
      end

      @(negedge clk);
      if (reset_at != 0 && k == last) begin
        m_hi = 32'h0; m_lo = 32'h0; m_terr = 1'b0;
        checkCtrl({tag, " after reset"}, k, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
      end else begin
        e_busy  = (k >= 1) && (k <= run_end);
        e_clr   = (k == 1);
        e_init  = (k >= 2) && (k <= run_end);
        e_done  = (n_done != 0) && (k == 2 + n_done);
        got_res = (n_done != 0) && (k >= 2 + n_done);
        e_hi    = (k == 0) ? m_hi : (got_res ? rhi : old_hi);
        e_lo    = (k == 0) ? m_lo : (got_res ? rlo : old_lo);
        e_terr  = ((n_done == 0) && (k >= 2 + TIMEOUT)) ? 1'b1 : m_terr;
        checkCtrl(tag, k, sel_m && e_clr, sel_m && e_init, !sel_m && e_clr,
                  !sel_m && e_init, e_busy, e_done, e_hi, e_lo, e_terr);
      end
    end

    if (reset_at == 0) begin
      m_hi = (n_done != 0) ? rhi : old_hi;
      m_lo = (n_done != 0) ? rlo : old_lo;
      if (n_done == 0) m_terr = 1'b1;
    end
  endtask

  bit rm;
  int rn;

  initial begin
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    mult_done = 0; div_done = 0;
    mult_hi = 0; mult_lo = 0; div_hi = 0; div_lo = 0;
    m_hi = 0; m_lo = 0; m_terr = 0;

    doReset();

    // -2 * 3 with done on the 33rd RUN cycle.
    runOp("mult33", 1, 0, 33, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0, 32'h0, 0);

    // Simultaneous starts: multiplier wins.
    runOp("both", 1, 1, $urandom_range(1, 39), 32'h0, 32'h0000000C, 0, 0, 32'h0, 0);

    // Timeout with known prior HI/LO.
    writeHiLo(1, 0, 32'h11111111);
    writeHiLo(0, 1, 32'h22222222);
    runOp("timeout", 1, 0, 0, 32'hAAAAAAAA, 32'hBBBBBBBB, 0, 0, 32'h0, 0);

    // Idle mthi, then a run with random ignored writes during RUN.
    writeHiLo(1, 0, 32'hDEADBEEF);
    runOp("mthi_run", 1, 0, $urandom_range(5, 34), 32'h00000042, 32'h00000099, 0, 0, 32'h0, 0);
    writeHiLo(1, 1, 32'h5A5A5A5A);

    // Reset during RUN cycle 10 also clears the sticky error.
    runOp("reset_run", 1, 0, 33, 32'h12345678, 32'h9ABCDEF0, 0, 0, 32'h0, 10);

    // 7 / 2 then an immediate multiply right after done.
    runOp("div", 0, 1, $urandom_range(1, 39), 32'h1, 32'h3, 0, 0, 32'h0, 0);
    runOp("mult_after_div", 1, 0, $urandom_range(1, 39), $urandom, $urandom, 0, 0, 32'h0, 0);

    // Done on the final allowed cycle beats the timeout; shortest run.
    runOp("done_at_limit", 0, 1, TIMEOUT, 32'hCAFEF00D, 32'h0BADBEEF, 0, 0, 32'h0, 0);
    runOp("done_first", 1, 0, 1, 32'h01020304, 32'h05060708, 0, 0, 32'h0, 0);

    // Write and start in the same idle cycle.
    runOp("write_and_start", 0, 1, 3, 32'h77777777, 32'h88888888, 1, 1, 32'h33333333, 0);

    for (int i = 0; i < 8; i++) begin
      rm = ($urandom % 2) == 1;
      rn = ($urandom % 8 == 0) ? 0 : $urandom_range(1, TIMEOUT);
      runOp($sformatf("rand%0d", i), rm, !rm || (($urandom % 2) == 1), rn,
            $urandom, $urandom, ($urandom % 2) == 1, ($urandom % 2) == 1,
            $urandom, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
